regfile_multiport: RTL and testbench

- Parametrised successor to the single-write register file: configurable read/write port counts, width-masked writes with zero- or sign-extension, write-to-read bypass, and a per-register busy scoreboard for the pipelined core.
- Sits between decode/issue (reads, reservations) and writeback (writes, releases).

---
 rtl/regfile_multiport.sv | 154 +++++++++++++++
 tb/tb_regfile_multiport.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-port architectural register file with width-masked
// writes (zero/sign extension), same-cycle write-to-read bypass, and a
// per-register busy scoreboard for the issue/writeback handshake.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   defined   -> register 0 is hardwired to zero: reads return 0 and not busy,
//                writes and reserves of address 0 are discarded.
//   undefined -> register 0 is an ordinary register.
module regfile_multiport #(
  parameter int REG_NUMBER        = 32,
  parameter int REG_ADDR_WIDTH    = $clog2(REG_NUMBER),
  parameter int REG_WIDTH_IN_BYTE = 4,
  parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8,
  parameter int NUM_READ          = 3,
  parameter int NUM_WRITE         = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_READ*REG_ADDR_WIDTH-1:0]    read_addr,
  output logic [NUM_READ*REG_WIDTH_IN_BIT-1:0]  read_data,
  output logic [NUM_READ-1:0]                   read_busy,
  input  logic [NUM_WRITE-1:0]                  write_enable,
  input  logic [NUM_WRITE*4-1:0]                write_width,
  input  logic [NUM_WRITE-1:0]                  write_signed,
  input  logic [NUM_WRITE-1:0]                  write_release,
  input  logic [NUM_WRITE*REG_ADDR_WIDTH-1:0]   write_reg_addr,
  input  logic [NUM_WRITE*REG_WIDTH_IN_BIT-1:0] write_data,
  input  logic                                  reserve_enable,
  input  logic [REG_ADDR_WIDTH-1:0]             reserve_addr,
  output logic                                  write_error
);

  localparam int W  = REG_WIDTH_IN_BIT;
  localparam int AW = REG_ADDR_WIDTH;

  // Width codes understood by the write ports.
  localparam logic [3:0] WIDTH_BYTE = 4'd1;
  localparam logic [3:0] WIDTH_HALF = 4'd2;
  localparam logic [3:0] WIDTH_WORD = 4'd4;

  logic [W-1:0]          regs [REG_NUMBER];
  logic [REG_NUMBER-1:0] busy;
  logic [REG_NUMBER-1:0] busy_next;

  logic [AW-1:0]         waddr    [NUM_WRITE];
  logic [W-1:0]          ext_data [NUM_WRITE];
  logic [NUM_WRITE-1:0]  width_ok;
  logic [NUM_WRITE-1:0]  accepted;
  logic [NUM_WRITE-1:0]  releasing;
  logic                  reserve_ok;
  logic [AW-1:0]         raddr    [NUM_READ];

  // True when the width code selects a supported access size.
  function automatic logic width_valid(input logic [3:0] code);
    return (code == WIDTH_BYTE) || (code == WIDTH_HALF) || (code == WIDTH_WORD);
  endfunction

  // Narrow the incoming data to the access size and refill the upper bits
  // with zero or the access sign bit. Word (and any other code) passes through.
  function automatic logic [W-1:0] extend_value(input logic [W-1:0] d,
                                                input logic [3:0]   code,
                                                input logic         sgn);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < W; i++) begin
      if (code == WIDTH_BYTE && i >= 8)
        r[i] = sgn & d[7];
      else if (code == WIDTH_HALF && i >= 16)
        r[i] = sgn & d[15];
    end
    return r;
  endfunction

  // False for addresses whose state is hardwired and must never change.
  function automatic logic addr_live(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return (a != '0);
`else
    return 1'b1 | (a == a);
`endif
  endfunction

  // Decode each write port: destination, extended value, and whether it lands.
  always_comb begin
    for (int p = 0; p < NUM_WRITE; p++) begin
      waddr[p]     = write_reg_addr[p*AW +: AW];
      width_ok[p]  = width_valid(write_width[p*4 +: 4]);
      ext_data[p]  = extend_value(write_data[p*W +: W], write_width[p*4 +: 4],
                                  write_signed[p]);
      accepted[p]  = write_enable[p] & width_ok[p] & addr_live(waddr[p]);
      releasing[p] = accepted[p] & write_release[p];
    end
    reserve_ok = reserve_enable & addr_live(reserve_addr);
  end

  // Register storage: later (higher-index) ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUMBER; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WRITE; p++)
        if (accepted[p]) regs[waddr[p]] <= ext_data[p];
    end
  end

  // Next scoreboard state: releases clear first, then a reserve re-sets,
  // so a new reservation always survives the older instruction's release.
  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NUM_WRITE; p++)
      if (releasing[p]) busy_next[waddr[p]] = 1'b0;
    if (reserve_ok) busy_next[reserve_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Flag any enabled write carrying an unsupported width code.
  always_ff @(posedge clk) begin
    if (reset) write_error <= 1'b0;
    else       write_error <= |(write_enable & ~width_ok);
  end

  // Unpack the read addresses.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) raddr[k] = read_addr[k*AW +: AW];
  end

  // Combinational reads with same-cycle bypass of data and busy release.
  always_comb begin
    logic [W-1:0] rd;
    logic         rel_hit;
    logic         rsv_hit;
    read_data = '0;
    read_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd      = regs[raddr[k]];
      rel_hit = 1'b0;
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (accepted[p] && waddr[p] == raddr[k]) rd = ext_data[p];
        if (releasing[p] && waddr[p] == raddr[k]) rel_hit = 1'b1;
      end
      rsv_hit = reserve_ok && (reserve_addr == raddr[k]);
      if (addr_live(raddr[k])) begin
        read_data[k*W +: W] = rd;
        read_busy[k]        = busy[raddr[k]] & ~(rel_hit & ~rsv_hit);
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: the stimulus thread drives one cycle
// of inputs and queues the outputs it expects for that cycle; a monitor on the
// falling edge pops and compares every queued expectation.
module tb_regfile_multiport;

  localparam int AW = 5;
  localparam int W  = 32;

  logic          clk;
  logic          reset;
  logic [3*AW-1:0] read_addr;
  logic [3*W-1:0]  read_data;
  logic [2:0]      read_busy;
  logic [1:0]      write_enable;
  logic [7:0]      write_width;
  logic [1:0]      write_signed;
  logic [1:0]      write_release;
  logic [2*AW-1:0] write_reg_addr;
  logic [2*W-1:0]  write_data;
  logic            reserve_enable;
  logic [AW-1:0]   reserve_addr;
  logic            write_error;

  regfile_multiport dut (
    .clk            (clk),
    .reset          (reset),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .read_busy      (read_busy),
    .write_enable   (write_enable),
    .write_width    (write_width),
    .write_signed   (write_signed),
    .write_release  (write_release),
    .write_reg_addr (write_reg_addr),
    .write_data     (write_data),
    .reserve_enable (reserve_enable),
    .reserve_addr   (reserve_addr),
    .write_error    (write_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;   // 0 read_data, 1 read_busy, 2 write_error
    int          port;
    logic [31:0] value;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        0:       act = read_data[e.port*W +: W];
        1:       act = {31'b0, read_busy[e.port]};
        default: act = {31'b0, write_error};
      endcase
      checks++;
      if (act !== e.value) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.value);
      end
    end
  end

  task automatic push(input string n, input int sel, input int port, input logic [31:0] v);
    exp_t e;
    e.name  = n;
    e.sel   = sel;
    e.port  = port;
    e.value = v;
    q.push_back(e);
  endtask

  task automatic exp_data(input string n, input int k, input logic [31:0] v);
    push(n, 0, k, v);
  endtask

  task automatic exp_busy(input string n, input int k, input logic v);
    push(n, 1, k, {31'b0, v});
  endtask

  task automatic exp_err(input string n, input logic v);
    push(n, 2, 0, {31'b0, v});
  endtask

  task automatic clear_inputs();
    reset          = 1'b0;
    read_addr      = '0;
    write_enable   = '0;
    write_width    = '0;
    write_signed   = '0;
    write_release  = '0;
    write_reg_addr = '0;
    write_data     = '0;
    reserve_enable = 1'b0;
    reserve_addr   = '0;
  endtask

  // Advance to just after the next rising edge and return to idle inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    read_addr[k*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [3:0] wdt, input logic sgn, input logic rel,
                    input logic [AW-1:0] a, input logic [31:0] d);
    write_enable[p]            = 1'b1;
    write_width[p*4 +: 4]      = wdt;
    write_signed[p]            = sgn;
    write_release[p]           = rel;
    write_reg_addr[p*AW +: AW] = a;
    write_data[p*W +: W]       = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    reserve_enable = 1'b1;
    reserve_addr   = a;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Post-reset sweep of every address on all three ports.
    for (int a = 0; a < 32; a++) begin
      cyc();
      rd(0, 5'(a));
      rd(1, 5'((a + 1) % 32));
      rd(2, 5'((a + 2) % 32));
      for (int k = 0; k < 3; k++) begin
        exp_data("reset_data", k, 32'h0);
        exp_busy("reset_busy", k, 1'b0);
      end
      exp_err("reset_err", 1'b0);
    end

    // Signed byte write with bypass, then stored value.
    cyc(); wr(0, 4'd1, 1'b1, 1'b0, 5'd5, 32'h0000_0080); rd(1, 5'd5);
    exp_data("byte_signed_bypass", 1, 32'hFFFF_FF80);
    cyc(); rd(0, 5'd5);
    exp_data("byte_signed_stored", 0, 32'hFFFF_FF80);

    // Unsigned half write with bypass, then stored value.
    cyc(); wr(0, 4'd2, 1'b0, 1'b0, 5'd5, 32'h1234_8001); rd(1, 5'd5);
    exp_data("half_unsigned_bypass", 1, 32'h0000_8001);
    cyc(); rd(0, 5'd5);
    exp_data("half_unsigned_stored", 0, 32'h0000_8001);

    // Two ports to the same address: port 1 wins.
    cyc(); wr(0, 4'd4, 1'b1, 1'b0, 5'd7, 32'hAAAA_AAAA);
    wr(1, 4'd4, 1'b0, 1'b0, 5'd7, 32'h5555_5555); rd(2, 5'd7);
    exp_data("prio_bypass", 2, 32'h5555_5555);
    cyc(); rd(2, 5'd7);
    exp_data("prio_stored", 2, 32'h5555_5555);

    // Scoreboard: reserve, release, and reserve-beats-release.
    cyc(); rsv(5'd9); rd(0, 5'd9);
    exp_busy("reserve_not_yet", 0, 1'b0);
    cyc(); rd(0, 5'd9);
    exp_busy("reserve_set", 0, 1'b1);
    cyc(); wr(1, 4'd4, 1'b0, 1'b1, 5'd9, 32'h0000_0011); rd(0, 5'd9);
    exp_busy("release_bypass", 0, 1'b0);
    exp_data("release_data", 0, 32'h0000_0011);
    cyc(); rd(0, 5'd9);
    exp_busy("release_held", 0, 1'b0);
    cyc(); rsv(5'd9);
    cyc(); rsv(5'd9); wr(0, 4'd4, 1'b0, 1'b1, 5'd9, 32'h0000_0022); rd(0, 5'd9);
    exp_busy("rsv_rel_same_cycle", 0, 1'b1);
    cyc(); rd(0, 5'd9);
    exp_busy("rsv_wins", 0, 1'b1);
    exp_data("rsv_rel_data", 0, 32'h0000_0022);
    cyc(); wr(0, 4'd4, 1'b0, 1'b1, 5'd9, 32'h0000_0033); rd(0, 5'd9);
    exp_busy("release_again", 0, 1'b0);
    cyc(); rd(0, 5'd9);
    exp_busy("release_again_held", 0, 1'b0);

    // Invalid width: suppressed, no bypass, release ignored, one-cycle error.
    cyc(); wr(0, 4'd4, 1'b0, 1'b0, 5'd3, 32'h0000_0033); rsv(5'd3);
    cyc(); wr(0, 4'd3, 1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF); rd(0, 5'd3);
    exp_data("bad_width_no_bypass", 0, 32'h0000_0033);
    exp_busy("bad_width_no_release", 0, 1'b1);
    exp_err("bad_width_err_before", 1'b0);
    cyc(); rd(0, 5'd3);
    exp_data("bad_width_unchanged", 0, 32'h0000_0033);
    exp_busy("bad_width_busy_kept", 0, 1'b1);
    exp_err("bad_width_err_pulse", 1'b1);
    cyc(); wr(1, 4'd4, 1'b0, 1'b1, 5'd3, 32'h0000_0044); rd(0, 5'd3);
    exp_data("good_after_bad", 0, 32'h0000_0044);
    exp_busy("good_release", 0, 1'b0);
    exp_err("bad_width_err_end", 1'b0);

    // Invalid high-priority port must not hide a valid lower port.
    cyc(); wr(0, 4'd4, 1'b0, 1'b0, 5'd7, 32'h0000_0077);
    wr(1, 4'd0, 1'b0, 1'b0, 5'd7, 32'h0000_0099); rd(1, 5'd7);
    exp_data("bad_hi_port_bypass", 1, 32'h0000_0077);
    cyc(); rd(1, 5'd7);
    exp_data("bad_hi_port_stored", 1, 32'h0000_0077);
    exp_err("bad_hi_port_err", 1'b1);

    // Register 0 behaviour.
    cyc(); wr(0, 4'd4, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF); rsv(5'd0); rd(0, 5'd0);
`ifdef REGFILE_ZERO_REG_EN
    exp_data("zero_reg_bypass", 0, 32'h0);
`else
    exp_data("reg0_bypass", 0, 32'hDEAD_BEEF);
`endif
    exp_busy("reg0_busy_now", 0, 1'b0);
    exp_err("reg0_err", 1'b0);
    cyc(); rd(0, 5'd0);
`ifdef REGFILE_ZERO_REG_EN
    exp_data("zero_reg_stored", 0, 32'h0);
    exp_busy("zero_reg_busy", 0, 1'b0);
`else
    exp_data("reg0_stored", 0, 32'hDEAD_BEEF);
    exp_busy("reg0_busy", 0, 1'b1);
`endif

    // Reset in the middle of a write burst clears everything.
    cyc(); wr(0, 4'd4, 1'b0, 1'b0, 5'd10, 32'h0000_1010);
    wr(1, 4'd4, 1'b0, 1'b0, 5'd11, 32'h0000_1111); rd(0, 5'd10);
    exp_data("burst_bypass", 0, 32'h0000_1010);
    cyc(); reset = 1'b1; wr(0, 4'd4, 1'b0, 1'b0, 5'd12, 32'h0000_1212);
    wr(1, 4'd3, 1'b0, 1'b0, 5'd13, 32'h0000_1313); rsv(5'd12);
    cyc(); rd(0, 5'd10); rd(1, 5'd11); rd(2, 5'd12);
    exp_data("rst_burst_10", 0, 32'h0);
    exp_data("rst_burst_11", 1, 32'h0);
    exp_data("rst_burst_12", 2, 32'h0);
    exp_busy("rst_busy_12", 2, 1'b0);
    exp_err("rst_err", 1'b0);
    cyc(); rd(0, 5'd5); rd(1, 5'd7); rd(2, 5'd0);
    exp_data("rst_old_5", 0, 32'h0);
    exp_data("rst_old_7", 1, 32'h0);
    exp_data("rst_old_0", 2, 32'h0);
    exp_busy("rst_busy_0", 2, 1'b0);

    cyc();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
